// File: rtl/fp_pkg.sv
// fp_pkg: shared fixed-point definitions for the arithmetic datapath
// (divider and multiplier).
//   state_t          - divider sequencing states (IDLE, CALC, FIX)
//   W_LEN_DEF        - default word length
//   W_FRACT_DEF      - default fractional bit count
//   fp_max / fp_min  - saturation constants as functions of the word length
package fp_pkg;

    localparam int unsigned W_LEN_DEF   = 16;
    localparam int unsigned W_FRACT_DEF = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Largest positive value, 2^(w-1)-1.
    function automatic logic [63:0] fp_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // 2^(w-1). This is the magnitude of the most negative value.
    // Truncated to w bits it is also that value's two's-complement pattern.
    function automatic logic [63:0] fp_min(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fp_div_if.sv
// fp_div_if: start/busy/done handshake plus operand and result bus of the
// fixed-point divider.
//   master: drives start, a, b; observes busy, done, quotient and the flags
//   slave : the divider side
interface fp_div_if #(
    parameter int unsigned W_len = fp_pkg::W_LEN_DEF
);
    logic             start;
    logic [W_len-1:0] a;
    logic [W_len-1:0] b;
    logic             busy;
    logic             done;
    logic [W_len-1:0] quotient;
    logic             overflow;
    logic             underflow;
    logic             div_by_zero;

    modport master (
        output start, a, b,
        input  busy, done, quotient, overflow, underflow, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, quotient, overflow, underflow, div_by_zero
    );
endinterface

// File: rtl/fp_div_core.sv
// fp_div_core: unsigned N-bit iterative restoring divider.
// The divider produces one quotient bit per step, starting with the MSB.
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture the numerator and the denominator, clear the remainder
//   step       : perform one restoring iteration
//   num        : N-bit unsigned numerator
//   den        : D_W-bit unsigned denominator, must be non-zero
//   quo        : N-bit quotient, complete after N steps
module fp_div_core #(
    parameter int unsigned N   = 30,
    parameter int unsigned D_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   num,
    input  logic [D_W-1:0] den,
    output logic [N-1:0]   quo
);

    logic [N-1:0]   num_sr;
    logic [D_W-1:0] den_r;
    logic [D_W-1:0] rem;

    logic [D_W:0]   rem_sh_c;
    logic           ge_c;
    logic [D_W:0]   rem_nx_c;

    // Trial subtraction. The remainder stays below den, so the shifted value fits in D_W+1 bits.
    always_comb begin
        rem_sh_c = {rem, num_sr[N-1]};
        ge_c     = rem_sh_c >= {1'b0, den_r};
        rem_nx_c = ge_c ? (rem_sh_c - {1'b0, den_r}) : rem_sh_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_sr <= '0;
            den_r  <= '0;
            rem    <= '0;
            quo    <= '0;
        end else if (load) begin
            num_sr <= num;
            den_r  <= den;
            rem    <= '0;
            quo    <= '0;
        end else if (step) begin
            num_sr <= {num_sr[N-2:0], 1'b0};
            rem    <= D_W'(rem_nx_c);
            quo    <= {quo[N-2:0], ge_c};
        end
    end

endmodule

// File: rtl/fp_div.sv
// fp_div: sequential signed fixed-point divider, quotient = a / b in Q(W_len, W_fract).
// It divides the magnitudes with fp_div_core, then applies the sign, the range flags
// and the optional saturation.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : fp_div_if slave (start, a, b / busy, done, quotient,
//                overflow, underflow, div_by_zero)
// Optional feature: define FP_DIV_SAT_EN to clamp overflow and underflow results to
// max/min. When it is not defined, those results wrap.
module fp_div
    import fp_pkg::*;
#(
    parameter int unsigned W_len   = W_LEN_DEF,
    parameter int unsigned W_fract = W_FRACT_DEF
) (
    input  logic      clk,
    input  logic      reset,
    fp_div_if.slave   bus
);

    localparam int unsigned N     = W_len + W_fract;
    localparam int unsigned CNT_W = $clog2(N);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic             a_neg_q;
    logic             dz_q;

    logic [W_len-1:0] abs_a_c;
    logic [W_len-1:0] abs_b_c;
    logic             b_zero_c;
    logic             core_load_c;
    logic             core_step_c;
    logic [N-1:0]     core_quo;

    logic             ovf_c;
    logic             udf_c;
    logic [W_len-1:0] res_c;

    // Operand magnitudes. The most negative value maps to 2^(W_len-1), which still fits unsigned.
    always_comb begin
        abs_a_c     = bus.a[W_len-1] ? W_len'(~bus.a + W_len'(1)) : bus.a;
        abs_b_c     = bus.b[W_len-1] ? W_len'(~bus.b + W_len'(1)) : bus.b;
        b_zero_c    = (bus.b == '0);
        core_load_c = (state == IDLE) && bus.start && !b_zero_c;
        core_step_c = (state == CALC);
    end

    fp_div_core #(
        .N   (N),
        .D_W (W_len)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (core_load_c),
        .step  (core_step_c),
        .num   ({abs_a_c, {W_fract{1'b0}}}),
        .den   (abs_b_c),
        .quo   (core_quo)
    );

    // Range check and signed result derived from the magnitude quotient (truncated toward zero).
    always_comb begin
        ovf_c = !sign_q && (core_quo > N'(fp_max(W_len)));
        udf_c =  sign_q && (core_quo > N'(fp_min(W_len)));
        res_c = sign_q ? W_len'(N'(0) - core_quo) : W_len'(core_quo);
`ifdef FP_DIV_SAT_EN
        if (ovf_c) begin
            res_c = W_len'(fp_max(W_len));
        end else if (udf_c) begin
            res_c = W_len'(fp_min(W_len));
        end
`endif
    end

    // Sequencer: latch on start, iterate N times, then publish the result with a one-cycle done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            sign_q          <= 1'b0;
            a_neg_q         <= 1'b0;
            dz_q            <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.overflow    <= 1'b0;
            bus.underflow   <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sign_q   <= bus.a[W_len-1] ^ bus.b[W_len-1];
                        a_neg_q  <= bus.a[W_len-1];
                        dz_q     <= b_zero_c;
                        bus.busy <= 1'b1;
                        cnt      <= CNT_W'(N - 1);
                        state    <= b_zero_c ? FIX : CALC;
                    end
                end
                CALC: begin
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                FIX: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                    if (dz_q) begin
                        // Divide by zero always returns the extreme value with the dividend's sign.
                        bus.quotient    <= a_neg_q ? W_len'(fp_min(W_len)) : W_len'(fp_max(W_len));
                        bus.overflow    <= 1'b0;
                        bus.underflow   <= 1'b0;
                        bus.div_by_zero <= 1'b1;
                    end else begin
                        bus.quotient    <= res_c;
                        bus.overflow    <= ovf_c;
                        bus.underflow   <= udf_c;
                        bus.div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div.sv
// tb_fp_div: directed self-checking bench for fp_div (Q16.14 defaults).
// Expected results come from an integer-division model. They are queued when an
// operation starts and popped when done is seen.
module tb_fp_div;

    localparam int unsigned WL = 16;
    localparam int unsigned WF = 14;

    typedef struct packed {
        logic [WL-1:0] q;
        logic          ov;
        logic          uf;
        logic          dz;
    } exp_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    exp_t sb[$];

    fp_div_if #(.W_len(WL)) bus ();

    fp_div #(.W_len(WL), .W_fract(WF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WL-1:0] a, input logic [WL-1:0] b);
        exp_t        e;
        longint      sa, sb_, ma, mb, q, r;
        logic [63:0] rv;
        logic        sgn;
        e = '0;
        if (b == '0) begin
            e.dz = 1'b1;
            e.q  = a[WL-1] ? 16'h8000 : 16'h7FFF;
            return e;
        end
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sb_ < 0) ? -sb_ : sb_;
        q   = (ma * (64'sd1 <<< WF)) / mb;
        sgn = (sa < 0) != (sb_ < 0);
        e.ov = !sgn && (q > 32767);
        e.uf = sgn && (q > 32768);
        r  = sgn ? -q : q;
        rv = r;
        e.q = rv[WL-1:0];
`ifdef FP_DIV_SAT_EN
        if (e.ov) e.q = 16'h7FFF;
        if (e.uf) e.q = 16'h8000;
`endif
        return e;
    endfunction

    // Start one operation on a negedge. Check busy, latency, result, hold and the done pulse width.
    task automatic do_op(input logic [WL-1:0] a, input logic [WL-1:0] b,
                         input int exp_lat, input bit mid_start);
        int   cnt;
        bit   busy_low;
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        sb.push_back(model(a, b));
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        cnt      = 0;
        busy_low = 1'b0;
        while (!bus.done && cnt < 80) begin
            @(negedge clk);
            cnt++;
            if (mid_start && cnt == 5) begin
                bus.start = 1'b1;
                bus.a     = 16'h7000;
                bus.b     = 16'h1000;
            end else begin
                bus.start = 1'b0;
            end
            if (!bus.done && !bus.busy) busy_low = 1'b1;
        end
        chk("latency", 32'(cnt), 32'(exp_lat));
        chk("busy_held", 32'(busy_low), 32'd0);
        if (!bus.done) return;
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk($sformatf("quot_%h_%h", a, b), 32'(bus.quotient), 32'(e.q));
        chk($sformatf("ovf_%h_%h", a, b), 32'(bus.overflow), 32'(e.ov));
        chk($sformatf("udf_%h_%h", a, b), 32'(bus.underflow), 32'(e.uf));
        chk($sformatf("dz_%h_%h", a, b), 32'(bus.div_by_zero), 32'(e.dz));
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 32'd0);
        chk("quot_hold", 32'(bus.quotient), 32'(e.q));
    endtask

    initial begin
        int   seen_done;
        logic [WL-1:0] ra, rb;
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_quot", 32'(bus.quotient), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_udf", 32'(bus.underflow), 32'd0);
        chk("rst_dz", 32'(bus.div_by_zero), 32'd0);
        reset = 1'b0;

        do_op(16'h2000, 16'h4000, 31, 1'b0);
        do_op(16'h4000, 16'h2000, 31, 1'b0);
        do_op(16'h1000, 16'hC000, 31, 1'b0);
        do_op(16'h4000, 16'hE000, 31, 1'b0);
        do_op(16'h6000, 16'hE000, 31, 1'b0);
        do_op(16'h0001, 16'h3000, 31, 1'b0);
        do_op(16'h0001, 16'hD000, 31, 1'b0);
        do_op(16'h8000, 16'h8000, 31, 1'b0);
        do_op(16'h1000, 16'h4000, 31, 1'b1);
        do_op(16'hC000, 16'h0000, 1, 1'b0);
        do_op(16'h4000, 16'h0000, 1, 1'b0);

        // Assert reset in the middle of an operation: outputs clear and no done follows.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h2000;
        bus.b     = 16'h4000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_quot", 32'(bus.quotient), 32'd0);
        chk("midrst_ovf", 32'(bus.overflow), 32'd0);
        chk("midrst_udf", 32'(bus.underflow), 32'd0);
        chk("midrst_dz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        chk("midrst_no_done", 32'(seen_done), 32'd0);

        do_op(16'h3000, 16'h4000, 31, 1'b0);
        repeat (4) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (rb == '0) rb = 16'h0123;
            do_op(ra, rb, 31, 1'b0);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_div.md
# fp_div

Sequential signed fixed-point divider, the inverse operation of the team's fixed-point multiplier, sharing its Q-format parameters and its overflow/underflow flag semantics. Computes quotient = a / b in the same format (two's-complement, W_fract fractional bits), using an iterative restoring algorithm that produces one quotient bit per clock. Sits beside the multiplier in the arithmetic datapath behind a start/busy/done handshake.

## Interface
- W_len, 16, word length of operands and quotient
- W_fract, 14, fractional bits of operands and quotient
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only when busy=0
- a  in  W_len  signed dividend
- b  in  W_len  signed divisor
- busy  out  1  operation in progress; start ignored
- done  out  1  one-cycle pulse; result outputs valid and held until next done
- quotient  out  W_len  signed result
- overflow  out  1  positive result exceeds 2^(W_len-1)-1 LSBs
- underflow  out  1  negative result below -2^(W_len-1) LSBs
- div_by_zero  out  1  b was zero

## Operation
- N = W_len + W_fract iterations. States: IDLE, CALC, FIX.
- IDLE: start=1 at an edge latches a, b, sign = a[MSB] XOR b[MSB], |a|, |b| (W_len-bit unsigned; -2^(W_len-1) yields 2^(W_len-1)). b≠0 → CALC with counter=N-1; b=0 → FIX with dz flag set.
- CALC: numerator |a|<<W_fract (N bits), restoring division MSB first: remainder = {remainder, next bit}; if remainder ≥ |b|, subtract and shift in 1, else shift in 0. Counter 0 → FIX.
- FIX: magnitude q (N bits, truncated toward zero). sign=0: overflow = q > 2^(W_len-1)-1. sign=1: underflow = q > 2^(W_len-1). Otherwise quotient = sign ? -q : q (low W_len bits). q=0 gives 0 with no flags. Pulse done; → IDLE.
- Divide by zero: div_by_zero=1, overflow=underflow=0, quotient = 0x7FFF-pattern (max) if a ≥ 0, min-pattern if a < 0, regardless of configuration.
- Flags are exclusive; all three are updated on every done.
- start while busy=1: ignored, no queuing.
- reset at any time: → IDLE, operation discarded, no done.

## Timing
- Reset values: busy=0, done=0, quotient=0, overflow=0, underflow=0, div_by_zero=0.
- start sampled at edge E0; busy=1 after E0. Iterations on E1..EN; outputs and done=1 after E(N+1); busy=0 after E(N+1); done=0 after E(N+2).
- Latency N+1 cycles (31 at defaults); next start accepted at E(N+2); throughput one operation per N+2 cycles.
- b=0: done after E1, busy=0 after E1.
- Operand inputs need be stable only at E0.

## Configuration
- FP_DIV_SAT_EN defined: on overflow quotient = 2^(W_len-1)-1; on underflow quotient = -2^(W_len-1).
- Not defined: quotient = low W_len bits of the signed result (wrap), flags unchanged.

## Structure
- Package fp_pkg: state enum (IDLE, CALC, FIX), Q-format default constants, max/min saturation constant functions of W_len, shared with the multiplier.
- Sub-module fp_div_core: unsigned N-bit iterative restoring divider (load, step, remainder/quotient registers); fp_div wraps it with sign handling, FSM, flags, saturation.

## Test plan
- a=0x2000 (0.5), b=0x4000 (1.0), start → done exactly 31 cycles after start edge, quotient=0x2000, all flags 0; busy high throughout.
- a=0x4000, b=0x2000 → overflow=1; quotient 0x7FFF with FP_DIV_SAT_EN, 0x8000 without.
- a=0x1000, b=0xC000 → 0xF000; a=0x4000, b=0xE000 → 0x8000, underflow=0 (exact minimum); a=0x6000, b=0xE000 → underflow=1, 0x8000 with macro.
- Truncation: a=0x0001, b=0x3000 → 0x0001; a=0x0001, b=0xD000 → 0xFFFF; a=0x8000, b=0x8000 → 0x4000.
- a=0xC000, b=0 → done one cycle after start, div_by_zero=1, quotient=0x8000; then a=0x4000, b=0 → 0x7FFF.
- start pulsed mid-operation → ignored, first result unaffected; reset asserted at iteration 10 → all outputs 0, no done; fresh start afterwards completes normally.
